// File: rtl/key_cnt_in.sv
// key_cnt_in: two-button (up/down) front end for the count display.
// Each raw key is synchronised, debounced and turned into a one-cycle flag.
// The flags step an 8-bit wrapping count in the range 0..CNT_TOP.
// Optional auto-repeat while a key is held: define KEY_REPEAT_EN.
module key_cnt_in #(
    parameter logic [19:0] CNT_MAX = 20'd999_999,
    parameter logic [7:0]  CNT_TOP = 8'd99,
    parameter logic [25:0] T_LONG  = 26'd49_999_999,
    parameter logic [23:0] T_REP   = 24'd9_999_999
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       key_up,
    input  logic       key_down,
    output logic       key_flag_up,
    output logic       key_flag_down,
    output logic [7:0] key_cnt
);

    // Index 0 is the up key, index 1 is the down key.
    logic [1:0] key_raw;
    logic [1:0] flag_w;
    logic [7:0] key_cnt_q;
    logic [7:0] key_cnt_d;

    assign key_raw = {key_down, key_up};

    for (genvar gi = 0; gi < 2; gi++) begin : g_key
        logic        sync1_q;
        logic        sync2_q;
        logic [19:0] cnt_db_q;
        logic [19:0] cnt_db_d;
        logic        press_hit;
        logic        rep_hit;
        logic        flag_q;

        // Two-flop synchroniser; idles released (high).
        always_ff @(posedge sys_clk or negedge sys_rst_n) begin
            if (!sys_rst_n) begin
                sync1_q <= 1'b1;
                sync2_q <= 1'b1;
            end else begin
                sync1_q <= key_raw[gi];
                sync2_q <= sync1_q;
            end
        end

        // Debounce window: clear on release, count up and saturate while held.
        always_comb begin
            cnt_db_d = cnt_db_q;
            if (sync2_q) begin
                cnt_db_d = 20'd0;
            end else if (cnt_db_q != CNT_MAX) begin
                cnt_db_d = cnt_db_q + 20'd1;
            end
        end

        // Debounce counter register.
        always_ff @(posedge sys_clk or negedge sys_rst_n) begin
            if (!sys_rst_n) begin
                cnt_db_q <= 20'd0;
            end else begin
                cnt_db_q <= cnt_db_d;
            end
        end

        // A press is accepted on the single step from CNT_MAX-1 to CNT_MAX.
        assign press_hit = !sync2_q && (cnt_db_q == CNT_MAX - 20'd1);

`ifdef KEY_REPEAT_EN
        logic [25:0] hold_q;
        logic [25:0] hold_d;
        logic        rep_phase_q;
        logic        rep_phase_d;
        logic        accepted;

        // The hold timer only runs once the press has been accepted.
        assign accepted = !sync2_q && (cnt_db_q == CNT_MAX);

        // Hold timer: first waits T_LONG, then fires every T_REP until release.
        always_comb begin
            hold_d      = hold_q;
            rep_phase_d = rep_phase_q;
            rep_hit     = 1'b0;
            if (sync2_q) begin
                hold_d      = 26'd0;
                rep_phase_d = 1'b0;
            end else if (accepted) begin
                if (!rep_phase_q && (hold_q == T_LONG - 26'd1)) begin
                    rep_hit     = 1'b1;
                    hold_d      = 26'd0;
                    rep_phase_d = 1'b1;
                end else if (rep_phase_q && (hold_q == {2'b00, T_REP} - 26'd1)) begin
                    rep_hit = 1'b1;
                    hold_d  = 26'd0;
                end else begin
                    hold_d = hold_q + 26'd1;
                end
            end
        end

        // Hold timer registers.
        always_ff @(posedge sys_clk or negedge sys_rst_n) begin
            if (!sys_rst_n) begin
                hold_q      <= 26'd0;
                rep_phase_q <= 1'b0;
            end else begin
                hold_q      <= hold_d;
                rep_phase_q <= rep_phase_d;
            end
        end
`else
        assign rep_hit = 1'b0;
`endif

        // Registered one-cycle flag per accepted press or repeat.
        always_ff @(posedge sys_clk or negedge sys_rst_n) begin
            if (!sys_rst_n) begin
                flag_q <= 1'b0;
            end else begin
                flag_q <= press_hit | rep_hit;
            end
        end

        assign flag_w[gi] = flag_q;
    end

`ifndef KEY_REPEAT_EN
    // Repeat timing parameters have no effect in this build.
    logic unused_rep_cfg;
    assign unused_rep_cfg = ^{T_LONG, T_REP};
`endif

    // Next count: wrap at both ends; simultaneous flags cancel.
    always_comb begin
        key_cnt_d = key_cnt_q;
        if (flag_w[0] && !flag_w[1]) begin
            key_cnt_d = (key_cnt_q == CNT_TOP) ? 8'd0 : key_cnt_q + 8'd1;
        end else if (flag_w[1] && !flag_w[0]) begin
            key_cnt_d = (key_cnt_q == 8'd0) ? CNT_TOP : key_cnt_q - 8'd1;
        end
    end

    // Count register, updated on the edge after the flag cycle.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            key_cnt_q <= 8'd0;
        end else begin
            key_cnt_q <= key_cnt_d;
        end
    end

    assign key_flag_up   = flag_w[0];
    assign key_flag_down = flag_w[1];
    assign key_cnt       = key_cnt_q;

endmodule

// File: tb/tb_key_cnt_in.sv
// Testbench for key_cnt_in with short timing (CNT_MAX=20, CNT_TOP=9,
// T_LONG=100, T_REP=30). Honours KEY_REPEAT_EN when the build defines it.
module tb_key_cnt_in;

    localparam int CNT_MAX = 20;
    localparam int CNT_TOP = 9;
    localparam int T_LONG  = 100;
    localparam int T_REP   = 30;

    logic       sys_clk;
    logic       sys_rst_n;
    logic       key_up;
    logic       key_down;
    logic       key_flag_up;
    logic       key_flag_down;
    logic [7:0] key_cnt;

    key_cnt_in #(
        .CNT_MAX(20'd20),
        .CNT_TOP(8'd9),
        .T_LONG (26'd100),
        .T_REP  (24'd30)
    ) dut (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .key_up       (key_up),
        .key_down     (key_down),
        .key_flag_up  (key_flag_up),
        .key_flag_down(key_flag_down),
        .key_cnt      (key_cnt)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int n_up     = 0;
    int n_dn     = 0;
    int n_both   = 0;
    int last_up_cyc = -1;

    // ---------------- reference model ----------------
    // A key's flag depends only on how long its (2-cycle delayed) level has
    // been low: exactly at CNT_MAX, and, with repeat, at CNT_MAX+T_LONG+n*T_REP.
    logic m_s1u = 1'b1, m_s2u = 1'b1, m_s1d = 1'b1, m_s2d = 1'b1;
    int   m_run_u = 0, m_run_d = 0;
    logic m_flag_up = 1'b0, m_flag_dn = 1'b0;
    int   m_cnt = 0;

    function automatic bit fires(input int run);
        if (run == CNT_MAX) return 1'b1;
`ifdef KEY_REPEAT_EN
        if (run >= CNT_MAX + T_LONG && ((run - CNT_MAX - T_LONG) % T_REP) == 0) return 1'b1;
`endif
        return 1'b0;
    endfunction

    always @(posedge sys_clk) begin : model
        int ru;
        int rd;
        if (!sys_rst_n) begin
            m_s1u <= 1'b1; m_s2u <= 1'b1; m_s1d <= 1'b1; m_s2d <= 1'b1;
            m_run_u <= 0; m_run_d <= 0;
            m_flag_up <= 1'b0; m_flag_dn <= 1'b0;
            m_cnt <= 0;
        end else begin
            if (m_flag_up && !m_flag_dn)      m_cnt <= (m_cnt + 1) % (CNT_TOP + 1);
            else if (m_flag_dn && !m_flag_up) m_cnt <= (m_cnt + CNT_TOP) % (CNT_TOP + 1);
            ru = m_s2u ? 0 : m_run_u + 1;
            rd = m_s2d ? 0 : m_run_d + 1;
            m_run_u   <= ru;
            m_run_d   <= rd;
            m_flag_up <= !m_s2u && fires(ru);
            m_flag_dn <= !m_s2d && fires(rd);
            m_s1u <= key_up;   m_s2u <= m_s1u;
            m_s1d <= key_down; m_s2d <= m_s1d;
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
    endtask

    // One cycle: compare outputs against the model, tally flags, then drive.
    task automatic step(input logic up, input logic dn, input logic rst);
        @(negedge sys_clk);
        cyc++;
        check("flag_up", int'(key_flag_up), int'(m_flag_up));
        check("flag_down", int'(key_flag_down), int'(m_flag_dn));
        check("cnt", int'(key_cnt), m_cnt);
        if (key_flag_up) begin n_up++; last_up_cyc = cyc; end
        if (key_flag_down) n_dn++;
        if (key_flag_up && key_flag_down) n_both++;
        key_up    = up;
        key_down  = dn;
        sys_rst_n = rst;
    endtask

    task automatic clear_tally();
        n_up = 0; n_dn = 0; n_both = 0; last_up_cyc = -1;
    endtask

    task automatic do_reset();
        repeat (3) step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        clear_tally();
    endtask

    // Clean press of the selected key(s), then release.
    task automatic press(input bit up, input bit dn);
        int hold = $urandom_range(25, 35);
        int rel  = $urandom_range(4, 8);
        repeat (hold) step(~up, ~dn, 1'b1);
        repeat (rel) step(1'b1, 1'b1, 1'b1);
    endtask

    initial begin
        int c0;
        int exp_cnt;
        sys_rst_n = 1'b1;
        key_up    = 1'b1;
        key_down  = 1'b1;
        #2 sys_rst_n = 1'b0;

        // Idle after reset.
        do_reset();
        repeat (200) step(1'b1, 1'b1, 1'b1);
        check("idle_up_flags", n_up, 0);
        check("idle_dn_flags", n_dn, 0);
        check("idle_cnt", int'(key_cnt), 0);
        $display("idle: cnt=%0d flags=%0d/%0d", key_cnt, n_up, n_dn);

        // Bouncy press.
        do_reset();
        for (int b = 0; b < 5; b++) begin
            repeat ($urandom_range(1, 3)) step(1'b0, 1'b1, 1'b1);
            repeat ($urandom_range(1, 3)) step(1'b1, 1'b1, 1'b1);
        end
        step(1'b0, 1'b1, 1'b1);
        c0 = cyc;
        repeat (49) step(1'b0, 1'b1, 1'b1);
        repeat (5) step(1'b1, 1'b1, 1'b1);
        check("bounce_flags", n_up, 1);
        check("bounce_latency", last_up_cyc - c0, CNT_MAX + 2);
        check("bounce_cnt", int'(key_cnt), 1);
        $display("bounce: flags=%0d latency=%0d cnt=%0d", n_up, last_up_cyc - c0, key_cnt);

        // Ten up presses wrap; one down press wraps the other way.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            press(1'b1, 1'b0);
            exp_cnt = (i + 1) % 10;
            check("up_seq_cnt", int'(key_cnt), exp_cnt);
            $display("up press %0d: cnt=%0d", i + 1, key_cnt);
        end
        check("up_seq_flags", n_up, 10);
        press(1'b0, 1'b1);
        check("down_wrap_cnt", int'(key_cnt), 9);
        $display("down press: cnt=%0d", key_cnt);

        // Both keys together at count 5.
        do_reset();
        repeat (5) press(1'b1, 1'b0);
        check("both_pre_cnt", int'(key_cnt), 5);
        clear_tally();
        press(1'b1, 1'b1);
        check("both_same_cycle", n_both, 1);
        check("both_up_flags", n_up, 1);
        check("both_dn_flags", n_dn, 1);
        check("both_cnt", int'(key_cnt), 5);
        $display("both: coincident=%0d cnt=%0d", n_both, key_cnt);

        // Reset in the middle of a debounce window with the key still held.
        do_reset();
        repeat (11) step(1'b0, 1'b1, 1'b1);
        repeat (2) step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        c0 = cyc;
        clear_tally();
        repeat (39) step(1'b0, 1'b1, 1'b1);
        repeat (5) step(1'b1, 1'b1, 1'b1);
        check("rst_mid_flags", n_up, 1);
        check("rst_mid_latency", last_up_cyc - c0, CNT_MAX + 2);
        check("rst_mid_cnt", int'(key_cnt), 1);
        $display("reset mid-window: latency=%0d cnt=%0d", last_up_cyc - c0, key_cnt);

        // Long hold of the up key.
        do_reset();
        repeat (200) step(1'b0, 1'b1, 1'b1);
        repeat (5) step(1'b1, 1'b1, 1'b1);
`ifdef KEY_REPEAT_EN
        check("hold_flags", n_up, 4);
        check("hold_cnt", int'(key_cnt), 4);
`else
        check("hold_flags", n_up, 1);
        check("hold_cnt", int'(key_cnt), 1);
`endif
        $display("long hold: flags=%0d cnt=%0d", n_up, key_cnt);

        // Random levels on both keys with occasional resets.
        do_reset();
        for (int s = 0; s < 250; s++) begin
            logic u;
            logic d;
            int   len;
            u   = 1'($urandom_range(0, 1));
            d   = 1'($urandom_range(0, 1));
            len = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : $urandom_range(1, 60);
            if ($urandom_range(0, 39) == 0) repeat ($urandom_range(1, 2)) step(u, d, 1'b0);
            repeat (len) step(u, d, 1'b1);
        end
        repeat (30) step(1'b1, 1'b1, 1'b1);
        $display("random: up flags=%0d down flags=%0d cnt=%0d", n_up, n_dn, key_cnt);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/key_cnt_in.md
Name: key_cnt_in

Overview:
- Input-side counterpart of the LED/segment count display path.
- Takes two raw push-buttons (up/down), synchronises and debounces each, and turns each accepted press into a single-cycle flag.
- Maintains the 8-bit count value that drives the display side's count input.
- Sits between the board keys and the display block, on the same 50 MHz system clock.

Parameters:
CNT_MAX, 20'd999_999, debounce window in clock cycles (20 ms at 50 MHz); key must stay pressed this long to be accepted.
CNT_TOP, 8'd99, highest count value; count range is 0..CNT_TOP.
T_LONG, 26'd49_999_999, hold time in cycles before auto-repeat starts (1 s); used only with the optional feature.
T_REP, 24'd9_999_999, auto-repeat period in cycles (200 ms); used only with the optional feature.

Ports:
sys_clk  input  1  system clock, 50 MHz
sys_rst_n  input  1  asynchronous active-low reset
key_up  input  1  raw up button, active low, asynchronous to sys_clk
key_down  input  1  raw down button, active low, asynchronous to sys_clk
key_flag_up  output  1  one-cycle pulse per accepted up press (or repeat)
key_flag_down  output  1  one-cycle pulse per accepted down press (or repeat)
key_cnt  output  8  current count, 0..CNT_TOP

Behaviour:
- Reset: the interface is fixed as one clock (sys_clk) with asynchronous, active-low reset (sys_rst_n).
  - Asserting reset immediately clears every register.
  - key_flag_up = 0, key_flag_down = 0, key_cnt = 8'd0.
  - Synchroniser stages reset to 1 (released). Debounce counters reset to 0.
- Synchronisation: each key passes through a 2-flop synchroniser before any use.
- Debounce, per key, with an independent counter cnt_db sized to CNT_MAX:
  - Synchronised key = 1 (released): cnt_db = 0.
  - Synchronised key = 0: cnt_db increments and saturates at CNT_MAX.
  - Flag is asserted for exactly one cycle in the cycle when cnt_db transitions from CNT_MAX-1 to CNT_MAX.
  - At most one flag per press. Any bounce to 1 before CNT_MAX restarts the window from 0.
- Latency: a clean press at cycle 0 gives the flag at cycle 2 + CNT_MAX (±1 for input sampling phase). key_cnt updates on the clock edge after the flag cycle.
- Count update, evaluated in the flag cycle:
  - Up only: if key_cnt == CNT_TOP then key_cnt becomes 0 (wrap), else key_cnt + 1.
  - Down only: if key_cnt == 0 then key_cnt becomes CNT_TOP (wrap), else key_cnt - 1.
  - Both flags in the same cycle: key_cnt unchanged. Both flags still pulse.
- Arithmetic is 8-bit unsigned. CNT_TOP must be at most 255.
- Holding a key indefinitely produces no further flags without the optional feature. Release resets cnt_db, so the next press is accepted.
- Reset mid-window: debounce progress is lost. A key still held when reset is released must satisfy a full new CNT_MAX window.

Optional Feature:
- Macro: KEY_REPEAT_EN.
- Defined: per key, after the first accepted flag, a hold counter runs.
  - When it reaches T_LONG cycles of continuous hold, a repeat flag is emitted.
  - Further repeat flags follow every T_REP cycles while the key stays held.
  - Each repeat flag updates key_cnt exactly as a press does, including wrap.
  - Releasing the key clears the hold counter immediately.
  - Repeats of both keys in the same cycle leave the count unchanged.
- Undefined: hold logic is absent. Behaviour is exactly one flag per press.

Test Plan:
- Simulation uses CNT_MAX=20, CNT_TOP=9, T_LONG=100, T_REP=30.
- Reset then idle 200 cycles -> key_cnt=0, both flags stay 0.
- key_up low with 5 bounces (1-3 cycle glitches), then held 50 cycles -> exactly one key_flag_up pulse, 20-23 cycles after the last bounce; key_cnt=1.
- Ten clean up presses from 0 -> key_cnt goes 1..9, then wraps to 0. One down press from 0 -> key_cnt=9.
- Both keys pressed in the same cycle, count=5 -> both flags pulse in the same cycle; key_cnt stays 5.
- Reset asserted at cycle 10 of a debounce window, released, key still held -> flag appears a full 20+2 cycles after reset release; key_cnt=1.
- KEY_REPEAT_EN defined, key_up held 200 cycles from count 0:
  - Flags at ~22, ~122, ~152 and ~182 cycles.
  - key_cnt=4.
  - Without the macro, the same stimulus gives key_cnt=1.
